// File: rtl/ld_sampler.sv
// ---------------------------------------------------------------------------
// ld_sampler
//
// Periodically reads two load cells (left, then right) through an SPI-attached
// A2D converter. A free-running period counter starts one sample round each
// time it wraps to 0. Each channel costs two SPI transactions: a command phase
// that selects the A2D channel, then a read phase that returns the conversion.
// The 12-bit results are presented on lft_ld / rght_ld and a one-cycle ld_vld
// pulse marks the end of a complete round.
//
// Configuration:
//   LD_SAMPLER_AVG_EN (macro) - when defined, each load output is the mean of
//                               the last 4 samples captured for that channel
//                               (14-bit running sum + 4-deep history, output is
//                               sum[13:2]; history starts at 0 so the first
//                               three outputs after reset ramp up). When
//                               undefined, outputs are the raw samples.
//
// Parameters:
//   fast_sim   - 1: 2^10-cycle sample period, 0: 2^20-cycle sample period
//   LFT_CHNL   - A2D channel of the left load cell
//   RGHT_CHNL  - A2D channel of the right load cell
//
// Ports:
//   clk          in   1   sole clock, rising edge
//   rst          in   1   synchronous active-high reset
//   spi_wrt      out  1   one-cycle pulse starting one SPI transaction
//   spi_cmd      out  16  command word, stable from spi_wrt until spi_done
//   spi_done     in   1   one-cycle pulse: transaction complete
//   spi_rd       in   16  returned data, valid in the spi_done cycle
//   lft_ld       out  12  left load value (registered)
//   rght_ld      out  12  right load value (registered)
//   ld_vld       out  1   one-cycle pulse, the cycle after rght_ld updates
//   spi_err      out  1   sticky transaction-timeout flag
//   o_dbg_state  out  3   current FSM state encoding (observation only)
//
// SPI handshake: spi_wrt is a single-cycle request carrying spi_cmd; exactly
// one transaction is outstanding until the matching single-cycle spi_done.
// spi_done is only honoured in the WAIT_CMD / WAIT_READ states, so a stray or
// late done pulse (IDLE, CMD, READ, or after a reset) has no effect. If no
// done arrives within 1024 cycles of spi_wrt, the round is abandoned and
// spi_err is set; a done landing in the 1024th cycle still counts.
// ---------------------------------------------------------------------------
module ld_sampler #(
    parameter int         fast_sim  = 1,
    parameter logic [2:0] LFT_CHNL  = 3'd0,
    parameter logic [2:0] RGHT_CHNL = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic        ld_vld,
    output logic        spi_err,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        WAIT_CMD  = 3'd2,
        READ      = 3'd3,
        WAIT_READ = 3'd4
    } state_t;

    localparam int         PER_W   = (fast_sim != 0) ? 10 : 20;
    // Counter value during the 1024th cycle after spi_wrt.
    localparam logic [9:0] TO_LAST = 10'd1023;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sel;          // 0: left channel, 1: right channel
    logic             w_sel_nxt;
    logic [15:0]      r_spi_cmd;
    logic [15:0]      w_cmd_nxt;
    logic [PER_W-1:0] r_period_cnt;
    logic [9:0]       r_to_cnt;
    logic             r_spi_err;
    logic             r_rght_upd;     // rght_ld was loaded this cycle
    logic             r_ld_vld;
    logic [11:0]      r_lft_ld;
    logic [11:0]      r_rght_ld;

    logic             w_wrap;
    logic             w_waiting;
    logic             w_to_expired;
    logic             w_spi_wrt;
    logic             w_capture;
    logic             w_err_set;
    logic [11:0]      w_sample;
    logic [11:0]      w_lft_val;
    logic [11:0]      w_rght_val;
    logic             w_unused_rd_hi;

    // Upper nibble of the A2D reply carries no conversion data.
    assign w_sample       = spi_rd[11:0];
    assign w_unused_rd_hi = ^spi_rd[15:12];

    // ------------------------------------------------------------------
    // Sample-period counter. Free-running; a round is launched on the
    // cycle where it rolls over to 0. A rollover seen outside IDLE is
    // simply not acted upon, so it is dropped rather than queued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PER_W'(1);
        end
    end

    assign w_wrap = (r_period_cnt == {PER_W{1'b1}});

    // ------------------------------------------------------------------
    // Transaction timeout counter. Cleared in the spi_wrt cycle, counts
    // while waiting. In the n-th cycle after spi_wrt it holds n-1.
    // ------------------------------------------------------------------
    assign w_waiting    = (r_state == WAIT_CMD) || (r_state == WAIT_READ);
    assign w_to_expired = w_waiting && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == CMD) || (r_state == READ)) begin
            r_to_cnt <= '0;
        end else if (w_waiting) begin
            r_to_cnt <= r_to_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cmd_nxt   = r_spi_cmd;
        w_spi_wrt   = 1'b0;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_wrap) begin
                    w_state_nxt = CMD;
                    w_sel_nxt   = 1'b0;
                    w_cmd_nxt   = {2'b00, LFT_CHNL, 11'h000};
                end
            end

            CMD: begin
                w_spi_wrt   = 1'b1;
                w_state_nxt = WAIT_CMD;
            end

            WAIT_CMD: begin
                // Done takes priority over an expiring timeout.
                if (spi_done) begin
                    w_state_nxt = READ;
                    w_cmd_nxt   = 16'h0000;
                end else if (w_to_expired) begin
                    w_state_nxt = IDLE;
                    w_err_set   = 1'b1;
                end
            end

            READ: begin
                w_spi_wrt   = 1'b1;
                w_state_nxt = WAIT_READ;
            end

            WAIT_READ: begin
                if (spi_done) begin
                    w_capture = 1'b1;
                    if (!r_sel) begin
                        w_state_nxt = CMD;
                        w_sel_nxt   = 1'b1;
                        w_cmd_nxt   = {2'b00, RGHT_CHNL, 11'h000};
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_to_expired) begin
                    w_state_nxt = IDLE;
                    w_err_set   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_spi_cmd  <= 16'h0000;
            r_spi_err  <= 1'b0;
            r_rght_upd <= 1'b0;
            r_ld_vld   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_spi_cmd  <= w_cmd_nxt;
            r_spi_err  <= r_spi_err | w_err_set;
            r_rght_upd <= w_capture & r_sel;
            // ld_vld trails the rght_ld update by one cycle so both loads
            // are already stable when it is seen.
            r_ld_vld   <= r_rght_upd;
        end
    end

    // ------------------------------------------------------------------
    // Optional 4-sample moving average
    // ------------------------------------------------------------------
`ifdef LD_SAMPLER_AVG_EN
    logic [11:0] r_lft_hist  [4];
    logic [11:0] r_rght_hist [4];
    logic [13:0] r_lft_sum;
    logic [13:0] r_rght_sum;
    logic [13:0] w_lft_sum_nxt;
    logic [13:0] w_rght_sum_nxt;

    // Running sum: drop the oldest sample, add the new one. The sum always
    // equals the total of the history entries, so it never overflows 14 bits.
    assign w_lft_sum_nxt  = r_lft_sum  - {2'b00, r_lft_hist[3]}  + {2'b00, w_sample};
    assign w_rght_sum_nxt = r_rght_sum - {2'b00, r_rght_hist[3]} + {2'b00, w_sample};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lft_sum  <= '0;
            r_rght_sum <= '0;
            for (int i = 0; i < 4; i++) begin
                r_lft_hist[i]  <= '0;
                r_rght_hist[i] <= '0;
            end
        end else if (w_capture) begin
            if (!r_sel) begin
                r_lft_sum     <= w_lft_sum_nxt;
                r_lft_hist[0] <= w_sample;
                for (int i = 1; i < 4; i++) begin
                    r_lft_hist[i] <= r_lft_hist[i-1];
                end
            end else begin
                r_rght_sum     <= w_rght_sum_nxt;
                r_rght_hist[0] <= w_sample;
                for (int i = 1; i < 4; i++) begin
                    r_rght_hist[i] <= r_rght_hist[i-1];
                end
            end
        end
    end

    assign w_lft_val  = w_lft_sum_nxt[13:2];
    assign w_rght_val = w_rght_sum_nxt[13:2];
`else
    assign w_lft_val  = w_sample;
    assign w_rght_val = w_sample;
`endif

    // ------------------------------------------------------------------
    // Load output registers; loaded the cycle after the delivering done.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lft_ld  <= '0;
            r_rght_ld <= '0;
        end else if (w_capture) begin
            if (!r_sel) begin
                r_lft_ld <= w_lft_val;
            end else begin
                r_rght_ld <= w_rght_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_wrt     = w_spi_wrt;
    assign spi_cmd     = r_spi_cmd;
    assign lft_ld      = r_lft_ld;
    assign rght_ld     = r_rght_ld;
    assign ld_vld      = r_ld_vld;
    assign spi_err     = r_spi_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ld_sampler.sv
// Testbench for ld_sampler: acts as the SPI responder, checks command words,
// transaction shape, captured loads, round timing, timeout and reset.
module tb_ld_sampler;

  localparam logic [15:0] CMD_L  = 16'h0000;  // {2'b00, 3'd0, 11'h000}
  localparam logic [15:0] CMD_R  = 16'h2000;  // {2'b00, 3'd4, 11'h000}
  localparam logic [15:0] CMD_RD = 16'h0000;
  localparam logic [2:0]  ST_IDLE      = 3'd0;
  localparam logic [2:0]  ST_WAIT_CMD  = 3'd2;
  localparam logic [2:0]  ST_WAIT_READ = 3'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd = 16'h0000;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        spi_err;
  logic [2:0]  dbg_state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ld_sampler #(
    .fast_sim  (1),
    .LFT_CHNL  (3'd0),
    .RGHT_CHNL (3'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_wrt     (spi_wrt),
    .spi_cmd     (spi_cmd),
    .spi_done    (spi_done),
    .spi_rd      (spi_rd),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .ld_vld      (ld_vld),
    .spi_err     (spi_err),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] cmd_q[$];
  logic [23:0] ld_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every ld_vld pulse must match one expected {lft, rght} pair.
  always @(negedge clk) begin
    if (ld_vld === 1'b1) begin
      if (ld_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ld_vld_unexpected: got ld_vld=1 with lft=0x%0h rght=0x%0h, none expected (cycle %0d)",
                 lft_ld, rght_ld, cyc);
      end else begin
        check("ld_pair", {8'h00, lft_ld, rght_ld}, {8'h00, ld_q.pop_front()});
      end
    end
  end

  // ---------------- reference model ----------------
`ifdef LD_SAMPLER_AVG_EN
  logic [11:0] m_lh [4];
  logic [11:0] m_rh [4];

  function automatic logic [23:0] model_round(input logic [11:0] l, input logic [11:0] r);
    logic [13:0] sl;
    logic [13:0] sr;
    for (int k = 3; k > 0; k--) begin
      m_lh[k] = m_lh[k-1];
      m_rh[k] = m_rh[k-1];
    end
    m_lh[0] = l;
    m_rh[0] = r;
    sl = '0;
    sr = '0;
    for (int k = 0; k < 4; k++) begin
      sl = sl + 14'(m_lh[k]);
      sr = sr + 14'(m_rh[k]);
    end
    return {sl[13:2], sr[13:2]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_lh[k] = '0;
      m_rh[k] = '0;
    end
  endtask
`else
  function automatic logic [23:0] model_round(input logic [11:0] l, input logic [11:0] r);
    return {l, r};
  endfunction

  task automatic model_clear();
  endtask
`endif

  // ---------------- driver tasks ----------------
  task automatic wait_wrt(input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      if (spi_wrt === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits for spi_wrt, checks the command, then answers after dly cycles
  // (or stays silent). Returns at the negedge dly+1 cycles after spi_wrt.
  task automatic run_txn(input string name, input logic [15:0] rd, input int dly,
                         input bit give_done, output int t);
    bit          ok;
    bit          stable;
    logic [15:0] exp_cmd;
    logic [15:0] held;
    wait_wrt(3000, t, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_wrt: got no spi_wrt within 3000 cycles, expected one (cycle %0d)", name, cyc);
      if (cmd_q.size() > 0) void'(cmd_q.pop_front());
      return;
    end
    exp_cmd = (cmd_q.size() > 0) ? cmd_q.pop_front() : 16'hDEAD;
    check({name, "_cmd"}, spi_cmd, exp_cmd);
    held   = spi_cmd;
    stable = 1'b1;
    for (int j = 1; j <= dly; j++) begin
      @(negedge clk);
      if (spi_wrt !== 1'b0 || spi_cmd !== held) stable = 1'b0;
      if (j == dly && give_done) begin
        spi_done = 1'b1;
        spi_rd   = rd;
      end
    end
    @(negedge clk);
    spi_done = 1'b0;
    spi_rd   = 16'($urandom);
    check({name, "_wrt_once_cmd_hold"}, {31'b0, stable}, 32'd1);
  endtask

  logic [11:0] cur_l = '0;
  logic [11:0] cur_r = '0;

  task automatic do_round(input string name, input logic [15:0] l_rd, input logic [15:0] r_rd,
                          input logic [11:0] el, input logic [11:0] er,
                          input int d1, input int d2, input int d3, input int d4,
                          output int t0);
    int t;
    cmd_q.push_back(CMD_L);
    cmd_q.push_back(CMD_RD);
    cmd_q.push_back(CMD_R);
    cmd_q.push_back(CMD_RD);
    ld_q.push_back({el, er});
    run_txn({name, "_lcmd"}, 16'($urandom), d1, 1'b1, t0);
    run_txn({name, "_lrd"}, l_rd, d2, 1'b1, t);
    check({name, "_lft_ld"}, lft_ld, el);
    run_txn({name, "_rcmd"}, 16'($urandom), d3, 1'b1, t);
    run_txn({name, "_rrd"}, r_rd, d4, 1'b1, t);
    check({name, "_rght_ld"}, rght_ld, er);
    check({name, "_vld_early"}, ld_vld, 1'b0);
    @(negedge clk);
    check({name, "_vld"}, ld_vld, 1'b1);
    check({name, "_idle"}, dbg_state, ST_IDLE);
    cur_l = el;
    cur_r = er;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [15:0] lft_rd;
    logic [15:0] rght_rd;
    logic [11:0] exp_lft;
    logic [11:0] exp_rght;
    int          dly;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          rel;
    int          t0;
    int          last;
    int          t;
    logic [15:0] rl;
    logic [15:0] rr;
    logic [23:0] e;
    logic [11:0] seq_l [5];
    logic [11:0] seq_r [5];

    model_clear();
    vecs[0] = '{16'hF123, 16'h0456, 12'h123, 12'h456, 20};
    vecs[1] = '{16'h0FFF, 16'hF000, 12'hFFF, 12'h000, 1};
    vecs[2] = '{16'hA000, 16'h0FFF, 12'h000, 12'hFFF, 7};
    vecs[3] = '{16'h5A5A, 16'hA5A5, 12'hA5A, 12'h5A5, 3};
    for (int i = 4; i < 6; i++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      vecs[i] = '{rl, rr, rl[11:0], rr[11:0], int'($urandom_range(1, 40))};
    end
`ifdef LD_SAMPLER_AVG_EN
    seq_l = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h400};
    seq_r = '{12'h200, 12'h400, 12'h600, 12'h800, 12'h800};
`else
    seq_l = '{12'h400, 12'h400, 12'h400, 12'h400, 12'h400};
    seq_r = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800};
`endif

    // ---- reset state ----
    repeat (4) @(negedge clk);
    check("rst_spi_wrt", spi_wrt, 1'b0);
    check("rst_spi_cmd", spi_cmd, 16'h0000);
    check("rst_lft_ld", lft_ld, 12'h000);
    check("rst_rght_ld", rght_ld, 12'h000);
    check("rst_ld_vld", ld_vld, 1'b0);
    check("rst_spi_err", spi_err, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    rel = cyc;

    // ---- spurious done while idle ----
    repeat (3) @(negedge clk);
    spi_done = 1'b1;
    spi_rd   = 16'hABCD;
    @(negedge clk);
    spi_done = 1'b0;
    @(negedge clk);
    check("spur0_state", dbg_state, ST_IDLE);
    check("spur0_lft", lft_ld, 12'h000);
    check("spur0_rght", rght_ld, 12'h000);
    check("spur0_wrt", spi_wrt, 1'b0);

    // ---- table-driven normal rounds ----
    last = 0;
    for (int i = 0; i < 6; i++) begin
      e = model_round(vecs[i].exp_lft, vecs[i].exp_rght);
      do_round($sformatf("round%0d", i), vecs[i].lft_rd, vecs[i].rght_rd, e[23:12], e[11:0],
               vecs[i].dly, vecs[i].dly, vecs[i].dly, vecs[i].dly, t0);
      if (i == 0) check("round_first_start", t0, rel + 1024);
      else        check($sformatf("round%0d_period", i), t0 - last, 1024);
      last = t0;
    end

    // ---- spurious done after a round ----
    repeat (5) @(negedge clk);
    spi_done = 1'b1;
    spi_rd   = 16'h0BAD;
    @(negedge clk);
    spi_done = 1'b0;
    @(negedge clk);
    check("spur1_state", dbg_state, ST_IDLE);
    check("spur1_lft", lft_ld, cur_l);
    check("spur1_rght", rght_ld, cur_r);

    // ---- done in the 1024th cycle wins over the timeout ----
    e = model_round(12'hABC, 12'hDEF);
    do_round("collide", 16'h0ABC, 16'h0DEF, e[23:12], e[11:0], 5, 1024, 2, 2, t0);
    check("collide_err", spi_err, 1'b0);

    // ---- timeout on the first command ----
    cmd_q.push_back(CMD_L);
    run_txn("tmo", 16'h0000, 1023, 1'b0, t);
    check("tmo_err_before", spi_err, 1'b0);
    check("tmo_state_wait", dbg_state, ST_WAIT_CMD);
    @(negedge clk);
    check("tmo_err_set", spi_err, 1'b1);
    check("tmo_state_idle", dbg_state, ST_IDLE);
    check("tmo_lft_keep", lft_ld, cur_l);
    check("tmo_rght_keep", rght_ld, cur_r);

    e = model_round(12'h321, 12'h654);
    do_round("post_tmo", 16'h7321, 16'h8654, e[23:12], e[11:0], 9, 9, 9, 9, t0);
    check("post_tmo_err_sticky", spi_err, 1'b1);

    // ---- reset during WAIT_READ of the right channel ----
    cmd_q.push_back(CMD_L);
    cmd_q.push_back(CMD_RD);
    cmd_q.push_back(CMD_R);
    cmd_q.push_back(CMD_RD);
    run_txn("rstr_lcmd", 16'h1111, 4, 1'b1, t);
    run_txn("rstr_lrd", 16'h0222, 4, 1'b1, t);
    run_txn("rstr_rcmd", 16'h3333, 4, 1'b1, t);
    run_txn("rstr_rrd", 16'h0444, 5, 1'b0, t);
    check("rstr_state_wait", dbg_state, ST_WAIT_READ);
    rst = 1'b1;
    @(negedge clk);
    check("rstr_wrt", spi_wrt, 1'b0);
    check("rstr_cmd", spi_cmd, 16'h0000);
    check("rstr_lft", lft_ld, 12'h000);
    check("rstr_rght", rght_ld, 12'h000);
    check("rstr_vld", ld_vld, 1'b0);
    check("rstr_err", spi_err, 1'b0);
    check("rstr_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    rel = cyc;
    model_clear();
    cur_l = '0;
    cur_r = '0;
    @(negedge clk);
    spi_done = 1'b1;
    spi_rd   = 16'h0777;
    @(negedge clk);
    spi_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_lft", lft_ld, 12'h000);
    check("late_done_rght", rght_ld, 12'h000);
    check("late_done_state", dbg_state, ST_IDLE);

    // ---- five identical rounds after reset (ramp when averaging) ----
    for (int i = 0; i < 5; i++) begin
      do_round($sformatf("seq%0d", i), 16'h0400, 16'h0800, seq_l[i], seq_r[i], 6, 6, 6, 6, t0);
      if (i == 0) check("seq_first_start", t0, rel + 1024);
      else        check($sformatf("seq%0d_period", i), t0 - last, 1024);
      last = t0;
    end

    repeat (4) @(negedge clk);
    check("cmd_q_empty", cmd_q.size(), 0);
    check("ld_q_empty", ld_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ld_sampler.md
LD_SAMPLER -- requirements
Module: ld_sampler

Interface
REQ-001 Parameter: fast_sim, default 1; 1 selects a 2^10-cycle sample period, 0 selects a 2^20-cycle sample period.
REQ-002 Parameter: LFT_CHNL, default 3'd0; A2D channel number of the left load cell.
REQ-003 Parameter: RGHT_CHNL, default 3'd4; A2D channel number of the right load cell.
REQ-004 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: spi_wrt  output  1  single-cycle pulse that starts one SPI transaction.
REQ-007 Port: spi_cmd  output  16  command word for the transaction; held stable from spi_wrt until spi_done.
REQ-008 Port: spi_done  input  1  single-cycle pulse from the SPI master when a transaction completes.
REQ-009 Port: spi_rd  input  16  data returned by the SPI master; valid in the spi_done cycle.
REQ-010 Port: lft_ld  output  12  left load value, registered.
REQ-011 Port: rght_ld  output  12  right load value, registered.
REQ-012 Port: ld_vld  output  1  one-cycle pulse, asserted the cycle after both loads of a round have updated.
REQ-013 Port: spi_err  output  1  sticky flag set on a transaction timeout.

Function
REQ-014 The period counter shall free-run and start one sample round when it wraps to 0; a wrap that occurs while a round is in progress shall be dropped, not queued.
REQ-015 Each round shall be ordered left channel first, then right; each channel shall use two SPI transactions: a command phase and a read phase.
REQ-016 Command phase: spi_cmd = {2'b00, chnl[2:0], 11'h000}. Read phase: spi_cmd = 16'h0000.
REQ-017 FSM states: IDLE, CMD, WAIT_CMD, READ, WAIT_READ; a channel-select bit shall distinguish left from right.
REQ-018 Transitions: IDLE->CMD on period wrap. CMD pulses spi_wrt and moves to WAIT_CMD. WAIT_CMD->READ on spi_done. READ pulses spi_wrt and moves to WAIT_READ. WAIT_READ on spi_done: for left, capture and go to CMD with right selected; for right, capture and go to IDLE.
REQ-019 Capture shall take spi_rd[11:0]; spi_rd[15:12] shall be ignored.
REQ-020 The captured value shall appear on lft_ld/rght_ld the cycle after the spi_done that delivers it; ld_vld shall pulse one cycle after rght_ld updates.
REQ-021 spi_done shall be ignored in IDLE, CMD and READ.
REQ-022 spi_wrt shall be exactly one cycle wide, with at most one transaction outstanding.
REQ-023 Timeout: if spi_done is not seen within 1024 cycles of spi_wrt, spi_err shall set, the round shall be abandoned to IDLE, and lft_ld/rght_ld shall keep their previous values with no ld_vld pulse.
REQ-024 If spi_done coincides with the timeout cycle, spi_done shall win and no error shall be flagged.

Reset
REQ-025 rst shall force IDLE and zero the period counter, timeout counter, lft_ld, rght_ld, ld_vld, spi_wrt and spi_err; spi_cmd shall reset to 16'h0000.
REQ-026 rst asserted mid-round shall abandon the round immediately; any spi_done arriving after reset is released shall be ignored.

Configuration
REQ-027 Macro LD_SAMPLER_AVG_EN: when defined, each output shall be the mean of the last 4 captured samples for its channel.
REQ-028 Averaging method: keep a 14-bit running sum and a 4-deep history per channel; the output is sum[13:2]; the history and sum reset to 0, so the first 3 outputs after reset ramp up.
REQ-029 When LD_SAMPLER_AVG_EN is undefined, the outputs shall equal the raw captured samples and no history storage shall exist.

Verification
REQ-030 Normal round: fast_sim=1; responder returns done 20 cycles after each spi_wrt with spi_rd=16'hF123 (left) and 16'h0456 (right) -> commands 16'h0000 (LFT_CHNL=0 command), 0000, 16'h2000 (RGHT_CHNL=4 command), 0000; lft_ld=12'h123, rght_ld=12'h456; one ld_vld pulse; next round starts 1024 cycles after the previous wrap.
REQ-031 Timeout: no spi_done after the first spi_wrt -> spi_err=1 at cycle 1024 after spi_wrt; outputs unchanged; the next round proceeds normally and spi_err stays 1.
REQ-032 Spurious done: spi_done pulses in IDLE -> no state change, no output change.
REQ-033 Reset mid-round: rst asserted in WAIT_READ(right) -> all outputs 0 the next cycle; a late spi_done is ignored; no ld_vld.
REQ-034 Averaging with LD_SAMPLER_AVG_EN: left samples 12'h400 for 5 rounds -> lft_ld sequence 12'h100, 12'h200, 12'h300, 12'h400, 12'h400. Without the macro -> 12'h400 every round.
REQ-035 Done/timeout collision: spi_done in the 1024th cycle -> data captured, spi_err stays 0.
